// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage.
package alu_pkg;

  localparam int unsigned FUNC_W = 3;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned IMM_W  = 16;

  // ALU function codes
  localparam logic [FUNC_W-1:0] ALU_ADD = 3'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB = 3'd1;
  localparam logic [FUNC_W-1:0] ALU_AND = 3'd2;
  localparam logic [FUNC_W-1:0] ALU_OR  = 3'd3;
  localparam logic [FUNC_W-1:0] ALU_NOR = 3'd4;
  localparam logic [FUNC_W-1:0] ALU_SLT = 3'd5;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [OP_W-1:0] FN_SLTU = 6'h2B;

  typedef enum logic {SEXT = 1'b0, ZEXT = 1'b1} ext_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control fields.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [OP_W-1:0]   funct,
  output logic [FUNC_W-1:0] func,
  output logic              use_imm,
  output ext_e              ext_type,
  output logic              dest_is_rd,
  output logic              wb_en,
  output logic              illegal
);

  // Unsupported encodings fall through to ADD with writeback suppressed.
  always_comb begin
    func       = ALU_ADD;
    use_imm    = 1'b0;
    ext_type   = SEXT;
    dest_is_rd = 1'b0;
    wb_en      = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest_is_rd = 1'b1;
        wb_en      = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: func = ALU_ADD;
          FN_SUB, FN_SUBU: func = ALU_SUB;
          FN_AND:          func = ALU_AND;
          FN_OR:           func = ALU_OR;
          FN_NOR:          func = ALU_NOR;
          FN_SLT, FN_SLTU: func = ALU_SLT;
          default: begin
            wb_en   = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        use_imm = 1'b1;
        wb_en   = 1'b1;
      end
      OP_ANDI: begin
        func     = ALU_AND;
        use_imm  = 1'b1;
        ext_type = ZEXT;
        wb_en    = 1'b1;
      end
      OP_ORI: begin
        func     = ALU_OR;
        use_imm  = 1'b1;
        ext_type = ZEXT;
        wb_en    = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        func    = ALU_SLT;
        use_imm = 1'b1;
        wb_en   = 1'b1;
      end
      OP_LW: begin
        use_imm = 1'b1;
        wb_en   = 1'b1;
      end
      OP_SW: begin
        use_imm = 1'b1;
      end
      OP_BEQ: begin
        func = ALU_SUB;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU: decode, operand select, bypass.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [OP_W-1:0]   in_funct,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [WIDTH-1:0]  in_rs_val,
  input  logic [WIDTH-1:0]  in_rt_val,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              fwd_mem_we,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [WIDTH-1:0]  fwd_mem_val,
  input  logic              fwd_wb_we,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic [WIDTH-1:0]  fwd_wb_val,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [FUNC_W-1:0] out_func,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_wb_en,
  output logic              out_illegal
);

  logic [FUNC_W-1:0] dec_func;
  logic              dec_use_imm;
  ext_e              dec_ext;
  logic              dec_dest_is_rd;
  logic              dec_wb_en;
  logic              dec_illegal;

  logic [WIDTH-1:0]  rs_fwd;
  logic [WIDTH-1:0]  rt_fwd;
  logic [WIDTH-1:0]  imm_ext;
  logic [WIDTH-1:0]  b_sel;
  logic [REG_AW-1:0] dest_sel;
  logic              wb_sel;

  alu_ctrl_decode u_decode (
    .opcode     (in_opcode),
    .funct      (in_funct),
    .func       (dec_func),
    .use_imm    (dec_use_imm),
    .ext_type   (dec_ext),
    .dest_is_rd (dec_dest_is_rd),
    .wb_en      (dec_wb_en),
    .illegal    (dec_illegal)
  );

  assign in_ready = ~stall;

  // rs bypass: MEM beats WB, register 0 never bypassed
  always_comb begin
    rs_fwd = in_rs_val;
    if (in_rs != '0) begin
      if (fwd_mem_we && (fwd_mem_rd == in_rs))    rs_fwd = fwd_mem_val;
      else if (fwd_wb_we && (fwd_wb_rd == in_rs)) rs_fwd = fwd_wb_val;
    end
  end

  // rt bypass: same rules as rs
  always_comb begin
    rt_fwd = in_rt_val;
    if (in_rt != '0) begin
      if (fwd_mem_we && (fwd_mem_rd == in_rt))    rt_fwd = fwd_mem_val;
      else if (fwd_wb_we && (fwd_wb_rd == in_rt)) rt_fwd = fwd_wb_val;
    end
  end

  // Immediate extension, B operand, destination and writeback qualification
  always_comb begin
    if (dec_ext == ZEXT) imm_ext = {{(WIDTH-IMM_W){1'b0}}, in_imm};
    else                 imm_ext = {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    b_sel    = dec_use_imm ? imm_ext : rt_fwd;
    dest_sel = dec_dest_is_rd ? in_rd : in_rt;
    wb_sel   = dec_wb_en && (dest_sel != '0);
  end

  // Pipeline register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_func    <= '0;
      out_dest    <= '0;
      out_wb_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_wb_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      out_a       <= rs_fwd;
      out_b       <= b_sel;
      out_func    <= dec_func;
      out_dest    <= dest_sel;
      out_wb_en   <= in_valid && wb_sel;
      out_illegal <= in_valid && dec_illegal;
    end
  end

endmodule
